// File: rtl/switch_egress_port.sv
// Switch egress port: filters crossbar words addressed to PORT_ID into a small FIFO and
// presents them to the downstream sink through a registered valid/ready output stage.
// Optional statistics counters are built when EGRESS_STATS_EN is defined; otherwise
// pkt_count and drop_count are tied to zero.
module switch_egress_port #(
  parameter logic [3:0]  PORT_ID = 4'd0,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        port_ready,
  input  logic        ready_in,
  output logic        valid_out,
  output logic [3:0]  source_out,
  output logic [3:0]  target_out,
  output logic [7:0]  data_out,
  output logic        overflow,
  output logic [15:0] pkt_count,
  output logic [7:0]  drop_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic        valid_q, valid_d;
  logic [3:0]  source_q, target_q;
  logic [7:0]  data_q;
  logic        overflow_q;

  logic full, empty, addr_match, push, pop, load, handshake;
  logic [15:0] head;

  // Full/empty come from registered occupancy, so a same-cycle pop never frees a slot early.
  assign full       = (count_q == FullCnt);
  assign empty      = (count_q == '0);
  assign addr_match = (in_data[7:4] == PORT_ID);
  assign push       = in_valid & addr_match & ~full;
  assign handshake  = valid_q & ready_in;
  assign head       = mem[rd_ptr_q];

  // Occupancy next-state: simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Output FSM next-state: load the head when idle, or refill on each handshake in SEND.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    pop     = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          valid_d = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (handshake) begin
          if (!empty) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // FSM state, output register and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      valid_q    <= 1'b0;
      source_q   <= '0;
      target_q   <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (load) begin
        data_q   <= head[15:8];
        target_q <= head[7:4];
        source_q <= head[3:0];
      end
      if (in_valid && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef EGRESS_STATS_EN
  logic [15:0] pkt_q;
  logic [7:0]  drop_q;
  logic        drop;

  // A word is dropped if misaddressed or if it meets a full FIFO; counted once either way.
  assign drop = in_valid & (~addr_match | full);

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      if (handshake && (pkt_q != '1)) pkt_q  <= pkt_q + 16'd1;
      if (drop && (drop_q != '1))     drop_q <= drop_q + 8'd1;
    end
  end

  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
`endif

  assign port_ready = ~full;
  assign valid_out  = valid_q;
  assign source_out = source_q;
  assign target_out = target_q;
  assign data_out   = data_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_switch_egress_port.sv
// Directed self-checking bench for switch_egress_port (PORT_ID=2, DEPTH=4).
module tb_switch_egress_port;

`ifdef EGRESS_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        port_ready;
  logic        ready_in;
  logic        valid_out;
  logic [3:0]  source_out;
  logic [3:0]  target_out;
  logic [7:0]  data_out;
  logic        overflow;
  logic [15:0] pkt_count;
  logic [7:0]  drop_count;

  int checks;
  int errors;

  switch_egress_port #(
    .PORT_ID(4'd2),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .port_ready(port_ready),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .source_out(source_out),
    .target_out(target_out),
    .data_out  (data_out),
    .overflow  (overflow),
    .pkt_count (pkt_count),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    ready_in = 1'b1;

    // Reset state.
    tick();
    tick();
    rst_n = 1'b1;
    check_val("rst_valid", 32'(valid_out), 32'd0);
    check_val("rst_ready", 32'(port_ready), 32'd1);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    check_val("rst_data", 32'(data_out), 32'd0);
    check_val("rst_pkt", 32'(pkt_count), 32'd0);
    check_val("rst_drop", 32'(drop_count), 32'd0);

    // Single word: accepted at edge N, visible after edge N+1.
    in_valid = 1'b1;
    in_data  = 16'hA521;
    tick();
    in_valid = 1'b0;
    check_val("single_lat1", 32'(valid_out), 32'd0);
    tick();
    check_val("single_valid", 32'(valid_out), 32'd1);
    check_val("single_data", 32'(data_out), 32'hA5);
    check_val("single_tgt", 32'(target_out), 32'd2);
    check_val("single_src", 32'(source_out), 32'd1);
    tick();
    check_val("single_done", 32'(valid_out), 32'd0);
    check_val("single_pkt", 32'(pkt_count), StatsEn ? 32'd1 : 32'd0);

    // Misroute: target 3 is not ours.
    in_valid = 1'b1;
    in_data  = 16'h3731;
    tick();
    in_valid = 1'b0;
    tick();
    check_val("mis_valid1", 32'(valid_out), 32'd0);
    tick();
    check_val("mis_valid2", 32'(valid_out), 32'd0);
    check_val("mis_drop", 32'(drop_count), StatsEn ? 32'd1 : 32'd0);

    // Backpressure: the first word moves to the output register, so the 4-entry FIFO
    // fills on the 5th write and the 6th write overflows.
    ready_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = {8'(8'h10 + i), 4'h2, 4'h5};
      tick();
      check_val($sformatf("bp_ready%0d", i), 32'(port_ready), (i >= 4) ? 32'd0 : 32'd1);
      check_val($sformatf("bp_ovf%0d", i), 32'(overflow), (i == 5) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;

    // Stall: output held stable while ready_in is low.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("stall_valid%0d", i), 32'(valid_out), 32'd1);
      check_val($sformatf("stall_data%0d", i), 32'(data_out), 32'h10);
      check_val($sformatf("stall_src%0d", i), 32'(source_out), 32'd5);
    end
    ready_in = 1'b1;
    // Drain: the remaining four words in order, the overflowed one never appears.
    for (int i = 1; i < 5; i++) begin
      tick();
      check_val($sformatf("drain_valid%0d", i), 32'(valid_out), 32'd1);
      check_val($sformatf("drain_data%0d", i), 32'(data_out), 32'(8'h10 + i));
    end
    tick();
    check_val("drain_end", 32'(valid_out), 32'd0);
    check_val("drain_ovf_sticky", 32'(overflow), 32'd1);
    check_val("drain_pkt", 32'(pkt_count), StatsEn ? 32'd6 : 32'd0);
    check_val("drain_drop", 32'(drop_count), StatsEn ? 32'd2 : 32'd0);

    // Reset mid-transfer with three words buffered (one in output, two in FIFO).
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = {8'(8'hC0 + i), 4'h2, 4'h7};
      tick();
    end
    in_valid = 1'b0;
    check_val("pre_rst_valid", 32'(valid_out), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_val("mrst_valid", 32'(valid_out), 32'd0);
    check_val("mrst_ready", 32'(port_ready), 32'd1);
    check_val("mrst_ovf", 32'(overflow), 32'd0);
    check_val("mrst_pkt", 32'(pkt_count), 32'd0);
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("post_rst_valid%0d", i), 32'(valid_out), 32'd0);
    end

    // Streaming: 8 back-to-back words, one delivered per cycle, two-cycle latency.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = {8'(8'h40 + i), 4'h2, 4'(i)};
      tick();
      if (i > 0) begin
        check_val($sformatf("str_valid%0d", i - 1), 32'(valid_out), 32'd1);
        check_val($sformatf("str_data%0d", i - 1), 32'(data_out), 32'(8'h40 + i - 1));
        check_val($sformatf("str_src%0d", i - 1), 32'(source_out), 32'(i - 1));
      end
    end
    in_valid = 1'b0;
    tick();
    check_val("str_valid7", 32'(valid_out), 32'd1);
    check_val("str_data7", 32'(data_out), 32'h47);
    tick();
    check_val("str_end", 32'(valid_out), 32'd0);
    check_val("str_pkt", 32'(pkt_count), StatsEn ? 32'd8 : 32'd0);
    check_val("str_drop", 32'(drop_count), 32'd0);
    check_val("str_ready", 32'(port_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
